// File: rtl/vrf_arb_pkg.sv
// Shared helpers for the VRF request arbiter.
//   id_width : width of a requester ID for n channels (at least 1 bit)
//   slice_lo : low bit of channel idx inside a packed per-channel bus of width w
package vrf_arb_pkg;

    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one direction of the VRF front end.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-channel request
//   en         : grant enable; when low, gnt is 0 and the pointer holds
//   gnt        : one-hot grant (combinational)
//   winner_id  : index of the first requester at or after the pointer,
//                valid whenever any req is set, independent of en
module rr_arbiter
    import vrf_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned ID_W = id_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] winner_id
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cand;
    logic            found;

    // Scan N channels starting at ptr; modulo keeps non-power-of-two N correct.
    always_comb begin
        found     = 1'b0;
        winner_id = '0;
        cand      = '0;
        gnt       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = ID_W'((32'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                winner_id = cand;
            end
        end
        if (found && en) begin
            gnt[winner_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (32'(winner_id) == N - 1) ? '0 : winner_id + 1'b1;
        end
    end

endmodule

// File: rtl/vrf_rr_arbiter.sv
// Multi-requester front end for the dual-port VRF BRAM.
// Port A serves NUM_PORTS read channels, port B serves NUM_PORTS write
// channels, each through its own round-robin arbiter. A read whose winning
// address matches the winning write address in the same cycle is held off
// for one cycle so the write commits first.
//   clk, rst_n           : clock, asynchronous active-low reset
//   bram_a_*             : BRAM port A (read only, we=0, din=0)
//   bram_b_*             : BRAM port B (write only, dout unused)
//   rd_req_i/rd_addr_i   : per-channel read requests, packed addresses
//   rd_gnt_o             : one-hot read grant (combinational)
//   rd_valid_o/rd_id_o/rd_data_o : returned read data and owning channel
//   wr_req_i/wr_addr_i/wr_data_i : per-channel write requests
//   wr_gnt_o             : one-hot write grant (combinational)
module vrf_rr_arbiter
    import vrf_arb_pkg::*;
#(
    parameter int unsigned VRF_ADDR_WIDTH = 10,
    parameter int unsigned VRF_DATA_WIDTH = 1024,
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned BRAM_RD_LAT    = 1,
    localparam int unsigned ID_W = id_width(NUM_PORTS)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    output logic [VRF_ADDR_WIDTH-1:0]           bram_a_addr_o,
    output logic                                bram_a_en_o,
    output logic                                bram_a_we_o,
    input  logic [VRF_DATA_WIDTH-1:0]           bram_a_dout_i,
    output logic [VRF_DATA_WIDTH-1:0]           bram_a_din_o,
    output logic [VRF_ADDR_WIDTH-1:0]           bram_b_addr_o,
    output logic [VRF_DATA_WIDTH-1:0]           bram_b_din_o,
    output logic                                bram_b_en_o,
    output logic                                bram_b_we_o,
    input  logic [VRF_DATA_WIDTH-1:0]           bram_b_dout_i,
    input  logic [NUM_PORTS-1:0]                rd_req_i,
    input  logic [NUM_PORTS*VRF_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_PORTS-1:0]                rd_gnt_o,
    output logic                                rd_valid_o,
    output logic [ID_W-1:0]                     rd_id_o,
    output logic [VRF_DATA_WIDTH-1:0]           rd_data_o,
    input  logic [NUM_PORTS-1:0]                wr_req_i,
    input  logic [NUM_PORTS*VRF_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_PORTS*VRF_DATA_WIDTH-1:0] wr_data_i,
    output logic [NUM_PORTS-1:0]                wr_gnt_o
);

    localparam int unsigned AW = VRF_ADDR_WIDTH;
    localparam int unsigned DW = VRF_DATA_WIDTH;

    logic [ID_W-1:0] rd_win;
    logic [ID_W-1:0] wr_win;
    logic [AW-1:0]   rd_sel_addr;
    logic [AW-1:0]   wr_sel_addr;
    logic [DW-1:0]   wr_sel_data;
    logic            rd_collide;
    logic            rd_arb_en;
    logic [ID_W-1:0] cmd_id;
    logic            unused_b_dout;

    assign unused_b_dout = ^bram_b_dout_i;

    assign rd_sel_addr = rd_addr_i[slice_lo(32'(rd_win), AW) +: AW];
    assign wr_sel_addr = wr_addr_i[slice_lo(32'(wr_win), AW) +: AW];
    assign wr_sel_data = wr_data_i[slice_lo(32'(wr_win), DW) +: DW];

    // Winners are computed before enable, so the comparison sees the read
    // that would have been granted; the write always proceeds.
    assign rd_collide = (|rd_req_i) && (|wr_req_i) && (rd_sel_addr == wr_sel_addr);
    assign rd_arb_en  = rst_n && !rd_collide;

    rr_arbiter #(.N(NUM_PORTS)) u_rd_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (rd_req_i),
        .en        (rd_arb_en),
        .gnt       (rd_gnt_o),
        .winner_id (rd_win)
    );

    rr_arbiter #(.N(NUM_PORTS)) u_wr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (wr_req_i),
        .en        (rst_n),
        .gnt       (wr_gnt_o),
        .winner_id (wr_win)
    );

    assign bram_a_we_o  = 1'b0;
    assign bram_a_din_o = '0;
    assign rd_data_o    = bram_a_dout_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_a_en_o   <= 1'b0;
            bram_a_addr_o <= '0;
            cmd_id        <= '0;
        end else begin
            bram_a_en_o <= |rd_gnt_o;
            if (|rd_gnt_o) begin
                bram_a_addr_o <= rd_sel_addr;
                cmd_id        <= rd_win;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_b_en_o   <= 1'b0;
            bram_b_we_o   <= 1'b0;
            bram_b_addr_o <= '0;
            bram_b_din_o  <= '0;
        end else begin
            bram_b_en_o <= |wr_gnt_o;
            bram_b_we_o <= |wr_gnt_o;
            if (|wr_gnt_o) begin
                bram_b_addr_o <= wr_sel_addr;
                bram_b_din_o  <= wr_sel_data;
            end
        end
    end

    // Valid/ID pipeline fed by the port A command stage, so the last stage
    // lines up with bram_a_dout_i BRAM_RD_LAT cycles after the command.
    logic [BRAM_RD_LAT-1:0]           vld_sr;
    logic [BRAM_RD_LAT-1:0][ID_W-1:0] id_sr;

    if (BRAM_RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_sr <= '0;
                id_sr  <= '0;
            end else begin
                vld_sr <= bram_a_en_o;
                id_sr  <= cmd_id;
            end
        end
    end else begin : g_latn
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_sr <= '0;
                id_sr  <= '0;
            end else begin
                vld_sr <= {vld_sr[BRAM_RD_LAT-2:0], bram_a_en_o};
                id_sr  <= {id_sr[BRAM_RD_LAT-2:0], cmd_id};
            end
        end
    end

    assign rd_valid_o = vld_sr[BRAM_RD_LAT-1];
    assign rd_id_o    = id_sr[BRAM_RD_LAT-1];

endmodule

// File: tb/tb_vrf_rr_arbiter.sv
// Bench for vrf_rr_arbiter: a BRAM_RD_LAT=1 instance with a behavioural
// BRAM, plus a BRAM_RD_LAT=3 instance sharing the same request inputs.
module tb_vrf_rr_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 64;
    localparam int unsigned NP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [NP-1:0]    rd_req, wr_req;
    logic [NP*AW-1:0] rd_addr, wr_addr;
    logic [NP*DW-1:0] wr_data;

    logic [AW-1:0] a_addr, b_addr;
    logic          a_en, a_we, b_en, b_we;
    logic [DW-1:0] a_dout, a_din, b_din, b_dout;
    logic [NP-1:0] rd_gnt, wr_gnt;
    logic          rd_valid;
    logic [1:0]    rd_id;
    logic [DW-1:0] rd_data;

    logic [AW-1:0] a_addr3, b_addr3;
    logic          a_en3, a_we3, b_en3, b_we3;
    logic [DW-1:0] a_dout3, a_din3, b_din3, b_dout3;
    logic [NP-1:0] rd_gnt3, wr_gnt3;
    logic          rd_valid3;
    logic [1:0]    rd_id3;
    logic [DW-1:0] rd_data3;

    assign b_dout  = '0;
    assign b_dout3 = '0;
    assign a_dout3 = '0;

    vrf_rr_arbiter #(
        .VRF_ADDR_WIDTH(AW), .VRF_DATA_WIDTH(DW), .NUM_PORTS(NP), .BRAM_RD_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .bram_a_addr_o(a_addr), .bram_a_en_o(a_en), .bram_a_we_o(a_we),
        .bram_a_dout_i(a_dout), .bram_a_din_o(a_din),
        .bram_b_addr_o(b_addr), .bram_b_din_o(b_din), .bram_b_en_o(b_en),
        .bram_b_we_o(b_we), .bram_b_dout_i(b_dout),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
        .rd_valid_o(rd_valid), .rd_id_o(rd_id), .rd_data_o(rd_data),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt)
    );

    vrf_rr_arbiter #(
        .VRF_ADDR_WIDTH(AW), .VRF_DATA_WIDTH(DW), .NUM_PORTS(NP), .BRAM_RD_LAT(3)
    ) dut3 (
        .clk(clk), .rst_n(rst_n),
        .bram_a_addr_o(a_addr3), .bram_a_en_o(a_en3), .bram_a_we_o(a_we3),
        .bram_a_dout_i(a_dout3), .bram_a_din_o(a_din3),
        .bram_b_addr_o(b_addr3), .bram_b_din_o(b_din3), .bram_b_en_o(b_en3),
        .bram_b_we_o(b_we3), .bram_b_dout_i(b_dout3),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt3),
        .rd_valid_o(rd_valid3), .rd_id_o(rd_id3), .rd_data_o(rd_data3),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt3)
    );

    // Behavioural 1-cycle read-first BRAM with a known preload pattern.
    logic [DW-1:0] mem [1 << AW];

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {32'hC0DE_0000 | 32'(a), 32'(a) ^ 32'h5A5A_5A5A};
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = init_word(AW'(i));
    end

    always @(posedge clk) begin
        if (b_en && b_we) mem[b_addr] <= b_din;
        if (a_en) a_dout <= mem[a_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  rd_req;
        logic [39:0] rd_addr;
        logic [3:0]  wr_req;
        logic [9:0]  wr_addr;
        logic [63:0] wr_data;
        logic [3:0]  e_rd_gnt;
        logic [3:0]  e_wr_gnt;
        logic        e_a_en;
        logic        e_b_en;
        logic        e_vld;
        logic [1:0]  e_id;
        logic [63:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] rq, input logic [39:0] ra,
                                input logic [3:0] wq, input logic [9:0] wa, input logic [63:0] wd,
                                input logic [3:0] erg, input logic [3:0] ewg,
                                input logic ea, input logic eb, input logic ev,
                                input logic [1:0] eid, input logic [63:0] ed);
        vec_t v;
        v.rd_req = rq; v.rd_addr = ra; v.wr_req = wq; v.wr_addr = wa; v.wr_data = wd;
        v.e_rd_gnt = erg; v.e_wr_gnt = ewg; v.e_a_en = ea; v.e_b_en = eb;
        v.e_vld = ev; v.e_id = eid; v.e_data = ed;
        return v;
    endfunction

    function automatic logic [39:0] rep(input logic [9:0] a);
        return {4{a}};
    endfunction

    localparam logic [39:0] RR = {10'h103, 10'h102, 10'h101, 10'h100};
    localparam logic [63:0] A5 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] DC = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] EE = 64'hFEED_FACE_CAFE_F00D;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            rq       ra          wq       wa      wd   erg      ewg    a  b  v  id  data
        vecs.push_back(mk(4'b0000, rep(10'h0),   4'b0100, 10'h010, A5, 4'b0000, 4'b0100, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0010, rep(10'h010), 4'b0000, 10'h0, 0,  4'b0010, 4'b0000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0000, rep(10'h0),   4'b0000, 10'h0, 0,  4'b0000, 4'b0000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, rep(10'h0),   4'b0000, 10'h0, 0,  4'b0000, 4'b0000, 0, 0, 1, 1, A5));
        vecs.push_back(mk(4'b1000, rep(10'h020), 4'b0000, 10'h0, 0,  4'b1000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1111, RR,           4'b0000, 10'h0, 0,  4'b0001, 4'b0000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1111, RR,           4'b0000, 10'h0, 0,  4'b0010, 4'b0000, 1, 0, 1, 3, init_word(10'h020)));
        vecs.push_back(mk(4'b1111, RR,           4'b0000, 10'h0, 0,  4'b0100, 4'b0000, 1, 0, 1, 0, init_word(10'h100)));
        vecs.push_back(mk(4'b1111, RR,           4'b0000, 10'h0, 0,  4'b1000, 4'b0000, 1, 0, 1, 1, init_word(10'h101)));
        vecs.push_back(mk(4'b1111, RR,           4'b0000, 10'h0, 0,  4'b0001, 4'b0000, 1, 0, 1, 2, init_word(10'h102)));
        vecs.push_back(mk(4'b1111, RR,           4'b0000, 10'h0, 0,  4'b0010, 4'b0000, 1, 0, 1, 3, init_word(10'h103)));
        vecs.push_back(mk(4'b1111, RR,           4'b0000, 10'h0, 0,  4'b0100, 4'b0000, 1, 0, 1, 0, init_word(10'h100)));
        vecs.push_back(mk(4'b1111, RR,           4'b0000, 10'h0, 0,  4'b1000, 4'b0000, 1, 0, 1, 1, init_word(10'h101)));
        vecs.push_back(mk(4'b0000, rep(10'h0),   4'b0000, 10'h0, 0,  4'b0000, 4'b0000, 1, 0, 1, 2, init_word(10'h102)));
        vecs.push_back(mk(4'b0000, rep(10'h0),   4'b0000, 10'h0, 0,  4'b0000, 4'b0000, 0, 0, 1, 3, init_word(10'h103)));
        vecs.push_back(mk(4'b0001, rep(10'h3FF), 4'b1000, 10'h3FF, DC, 4'b0000, 4'b1000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0001, rep(10'h3FF), 4'b0000, 10'h0, 0,  4'b0001, 4'b0000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0000, rep(10'h0),   4'b0000, 10'h0, 0,  4'b0000, 4'b0000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, rep(10'h0),   4'b0000, 10'h0, 0,  4'b0000, 4'b0000, 0, 0, 1, 0, DC));
        vecs.push_back(mk(4'b0100, rep(10'h050), 4'b0010, 10'h060, EE, 4'b0100, 4'b0010, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1000, rep(10'h070), 4'b0000, 10'h0, 0,  4'b1000, 4'b0000, 1, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0001, rep(10'h080), 4'b0000, 10'h0, 0,  4'b0001, 4'b0000, 1, 0, 1, 2, init_word(10'h050)));
        vecs.push_back(mk(4'b0000, rep(10'h0),   4'b0000, 10'h0, 0,  4'b0000, 4'b0000, 1, 0, 1, 3, init_word(10'h070)));
        vecs.push_back(mk(4'b0000, rep(10'h0),   4'b0000, 10'h0, 0,  4'b0000, 4'b0000, 0, 0, 1, 0, init_word(10'h080)));
        vecs.push_back(mk(4'b0000, rep(10'h0),   4'b0000, 10'h0, 0,  4'b0000, 4'b0000, 0, 0, 0, 0, 0));

        // Power-on reset with requests already asserted: grants must stay low.
        rst_n   = 1'b0;
        rd_req  = '1;
        wr_req  = '1;
        rd_addr = RR;
        wr_addr = {4{10'h300}};
        wr_data = '0;
        #3;
        chk("por rd_gnt", rd_gnt, 0);
        chk("por wr_gnt", wr_gnt, 0);
        chk("por a_en", a_en, 0);
        chk("por b_en", b_en, 0);
        chk("por rd_valid", rd_valid, 0);
        @(negedge clk);
        chk("por rd_gnt held", rd_gnt, 0);
        rd_req = '0;
        wr_req = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            rd_req  = vecs[k].rd_req;
            rd_addr = vecs[k].rd_addr;
            wr_req  = vecs[k].wr_req;
            wr_addr = {4{vecs[k].wr_addr}};
            wr_data = {4{vecs[k].wr_data}};
            #1;
            chk($sformatf("v%0d rd_gnt", k), rd_gnt, vecs[k].e_rd_gnt);
            chk($sformatf("v%0d wr_gnt", k), wr_gnt, vecs[k].e_wr_gnt);
            chk($sformatf("v%0d a_en", k), a_en, vecs[k].e_a_en);
            chk($sformatf("v%0d a_we", k), a_we, 0);
            chk($sformatf("v%0d b_en", k), b_en, vecs[k].e_b_en);
            chk($sformatf("v%0d b_we", k), b_we, vecs[k].e_b_en);
            chk($sformatf("v%0d rd_valid", k), rd_valid, vecs[k].e_vld);
            if (vecs[k].e_vld) begin
                chk($sformatf("v%0d rd_id", k), rd_id, vecs[k].e_id);
                chk($sformatf("v%0d rd_data", k), rd_data, vecs[k].e_data);
            end
            @(negedge clk);
        end

        // Mid-stream reset with reads in flight (rd ptr=1, wr ptr=2 here).
        rd_req  = '1;
        rd_addr = RR;
        wr_req  = '1;
        wr_addr = {4{10'h200}};
        wr_data = {4{64'h1}};
        #1;
        chk("pre_rst rd_gnt", rd_gnt, 4'b0010);
        chk("pre_rst wr_gnt", wr_gnt, 4'b0100);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst rd_valid", rd_valid, 1);
        chk("pre_rst a_en", a_en, 1);
        rst_n = 1'b0;
        #1;
        chk("rst rd_gnt", rd_gnt, 0);
        chk("rst wr_gnt", wr_gnt, 0);
        chk("rst a_en", a_en, 0);
        chk("rst a_addr", a_addr, 0);
        chk("rst b_en", b_en, 0);
        chk("rst b_we", b_we, 0);
        chk("rst b_addr", b_addr, 0);
        chk("rst b_din", b_din, 0);
        chk("rst rd_valid", rd_valid, 0);
        chk("rst rd_id", rd_id, 0);
        chk("rst rd_valid3", rd_valid3, 0);
        @(negedge clk);
        chk("rst held rd_gnt", rd_gnt, 0);
        chk("rst held a_en", a_en, 0);
        rd_req = '0;
        wr_req = '0;
        rst_n  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst%0d rd_valid", k), rd_valid, 0);
            chk($sformatf("post_rst%0d rd_valid3", k), rd_valid3, 0);
        end

        // Pointers restart at 0, then back-to-back reads ch0, ch1 seen on both latencies.
        rd_req  = 4'b0011;
        rd_addr = RR;
        wr_req  = '1;
        wr_addr = {4{10'h210}};
        #1;
        chk("restart rd_gnt", rd_gnt, 4'b0001);
        chk("restart wr_gnt", wr_gnt, 4'b0001);
        chk("restart rd_gnt3", rd_gnt3, 4'b0001);
        @(negedge clk);
        wr_req = '0;
        #1;
        chk("b2b rd_gnt", rd_gnt, 4'b0010);
        chk("b2b rd_gnt3", rd_gnt3, 4'b0010);
        @(negedge clk);
        rd_req = '0;
        for (int c = 2; c <= 7; c++) begin
            #1;
            chk($sformatf("lat3 c%0d rd_valid3", c), rd_valid3, (c == 4 || c == 5));
            if (c == 4 || c == 5) chk($sformatf("lat3 c%0d rd_id3", c), rd_id3, 64'(c - 4));
            chk($sformatf("lat1 c%0d rd_valid", c), rd_valid, (c == 2 || c == 3));
            if (c == 2 || c == 3) begin
                chk($sformatf("lat1 c%0d rd_id", c), rd_id, 64'(c - 2));
                chk($sformatf("lat1 c%0d rd_data", c), rd_data, init_word(AW'(10'h100 + c - 2)));
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vrf_rr_arbiter.md
# vrf_rr_arbiter

Parametrised multi-requester arbiter in front of the dual-port VRF BRAM. It replaces the single read/write router interface with NUM_PORTS independent read channels and NUM_PORTS independent write channels. Each side has its own round-robin arbiter: port A serves reads and port B serves writes. Read data returns through a latency-matched valid/ID pipeline, and same-cycle read/write collisions to one address are resolved in favour of the write.

## Interface
- VRF_ADDR_WIDTH, 10: BRAM address width.
- VRF_DATA_WIDTH, 1024: BRAM word width.
- NUM_PORTS, 4: requester channels per direction, ≥2.
- BRAM_RD_LAT, 1: BRAM read latency in cycles, ≥1.
- ID_W, $clog2(NUM_PORTS): requester ID width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bram_a_addr_o / bram_a_en_o / bram_a_we_o  out  VRF_ADDR_WIDTH/1/1  port A, read-only use; we is always 0.
- bram_a_dout_i  in  VRF_DATA_WIDTH  port A read data.
- bram_a_din_o  out  VRF_DATA_WIDTH  tied 0.
- bram_b_addr_o / bram_b_din_o / bram_b_en_o / bram_b_we_o  out  port B, write-only use.
- bram_b_dout_i  in  VRF_DATA_WIDTH  unused.
- rd_req_i  in  NUM_PORTS  read request per channel.
- rd_addr_i  in  NUM_PORTS*VRF_ADDR_WIDTH  packed read addresses; channel i is at [i*W +: W].
- rd_gnt_o  out  NUM_PORTS  one-hot read grant, combinational.
- rd_valid_o  out  1  read data valid.
- rd_id_o  out  ID_W  channel that owns rd_data_o.
- rd_data_o  out  VRF_DATA_WIDTH  read data.
- wr_req_i  in  NUM_PORTS  write request per channel.
- wr_addr_i / wr_data_i  in  packed per channel  write address and data.
- wr_gnt_o  out  NUM_PORTS  one-hot write grant, combinational.

## Operation
- **Request handshake.** A requester holds req, addr and data stable until it sees gnt. The transfer happens at the rising edge where req & gnt are both 1. A requester that keeps req high after that edge is making a new request.
- **Grant rule.** gnt is combinational from req and the arbitration pointer, and is never asserted without the matching req.
- **Round-robin.** Each direction keeps a pointer ptr of width ID_W, reset to 0. The winner is the first requesting channel at or after ptr, wrapping modulo NUM_PORTS. After a grant, ptr moves to winner+1, wrapping to 0 after NUM_PORTS-1. With no grant, ptr holds.
- **Write path.** When a write is granted in cycle t, port B registers en=1, we=1, addr and din, which are visible in cycle t+1. In any cycle with no granted write, en and we are 0.
- **Read path.** When a read is granted in cycle t, port A registers en=1 and addr, visible in cycle t+1.
  - A valid/ID shift register of length BRAM_RD_LAT tracks the request alongside the BRAM.
  - rd_valid_o=1, rd_id_o=winner and rd_data_o=bram_a_dout_i are all presented in cycle t+1+BRAM_RD_LAT.
  - rd_data_o is passed straight through from dout. It is don't-care when rd_valid_o=0.
- **Collision.** If the read winner's address equals the write winner's address in the same cycle, the read grant is withheld: rd_gnt_o=0 and the read pointer holds. The write proceeds. The read is re-arbitrated in the next cycle.
- **Idle.** With no requests, all enables and grants are 0.
- **Reset.** rst_n low at any time takes effect immediately:
  - bram_*_en_o, bram_*_we_o, bram addresses, bram_b_din_o, the valid pipeline, rd_valid_o, rd_id_o and both pointers all go to 0.
  - rd_gnt_o and wr_gnt_o are 0 while rst_n is low, regardless of req.
  - In-flight reads are discarded and produce no rd_valid_o after reset is released.

## Timing
- Grant: 0 cycles after req, combinational.
- BRAM command: 1 cycle after the grant.
- Read data: valid 1+BRAM_RD_LAT cycles after the grant (2 with the default).
- Throughput: one read and one write per cycle.
- Fairness: under continuous requests from all channels, each channel is granted at least once every NUM_PORTS cycles per direction, excluding collision stalls.
- Read/write ordering: a read granted in a later cycle than a write to the same address returns the new data. This holds when the BRAM is configured write-first or read-first, because the write commits one edge earlier.

## Structure
- A shared package vrf_arb_pkg holds the derived ID_W function and the packed-slice index helpers.
- One sub-module, rr_arbiter (params N; ports req, en, gnt, winner_id), is instantiated twice, once per direction. Its en input is used to suppress the read grant on a collision.
- The top level holds the address muxes, the port registers, the collision comparator and the valid/ID pipeline.

## Test plan
- **Reset:** assert rst_n=0 mid-stream with 2 reads in flight → all outputs 0 at once. No rd_valid_o after release. Both pointers restart at channel 0.
- **Single write then read:** channel 2 writes 0xA5… to addr 0x010, then channel 1 reads 0x010 → wr_gnt_o=0100, rd_gnt_o=0010. rd_valid_o arrives 2 cycles after rd_gnt_o with rd_id_o=1 and data 0xA5….
- **Round-robin:** all 4 read req held high for 8 cycles → grants in the order 0,1,2,3,0,1,2,3. rd_id_o returns the same sequence, 2 cycles later.
- **Collision:** read ch0 and write ch3 both to addr 0x3FF in the same cycle → wr_gnt_o=1000 and rd_gnt_o=0000. The next cycle gives rd_gnt_o=0001, and the read returns the newly written data.
- **Latency parameter:** BRAM_RD_LAT=3 with back-to-back reads from ch0 and ch1 → rd_valid_o high in 2 consecutive cycles, 4 cycles after each grant, with IDs 0 then 1.
- **Wrap and idle:** only ch3 requests, then only ch0 → ptr wraps 3→0, each grant is immediate, and en is 0 in the idle cycles.
